key_cmd_gen: RTL and testbench

KEY_CMD_GEN -- requirements
Module: key_cmd_gen

---
 rtl/frog_pkg.sv | 41 ++++
 rtl/cmd_fifo.sv | 55 +++++
 rtl/key_cmd_gen.sv | 111 +++++++++++
 tb/tb_key_cmd_gen.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/frog_pkg.sv
// rtl/frog_pkg.sv - shared direction/state types, keycode constants and keycode decode
package frog_pkg;

    typedef enum logic [1:0] {
        UP    = 2'b00,
        LEFT  = 2'b01,
        RIGHT = 2'b10,
        DOWN  = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        REPEAT
    } state_t;

    localparam logic [15:0] KEY_UP    = 16'h001A;
    localparam logic [15:0] KEY_LEFT  = 16'h0004;
    localparam logic [15:0] KEY_RIGHT = 16'h0007;
    localparam logic [15:0] KEY_DOWN  = 16'h0016;

    typedef struct packed {
        logic valid;
        dir_t dir;
    } key_t;

    function automatic key_t decode_key(input logic [15:0] code);
        key_t k;
        k.valid = 1'b1;
        k.dir   = UP;
        case (code)
            KEY_UP:    k.dir = UP;
            KEY_LEFT:  k.dir = LEFT;
            KEY_RIGHT: k.dir = RIGHT;
            KEY_DOWN:  k.dir = DOWN;
            default:   k.valid = 1'b0;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// rtl/cmd_fifo.sv - power-of-two command FIFO with wrapping pointers and a separate occupancy counter
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic                       frame_clk,
    input  logic                       Reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge frame_clk) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/key_cmd_gen.sv
// rtl/key_cmd_gen.sv - keyboard hold/auto-repeat state machine feeding a motion command FIFO
module key_cmd_gen
    import frog_pkg::*;
#(
    parameter int REPEAT_DELAY  = 30,
    parameter int REPEAT_PERIOD = 10,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic        frame_clk,
    input  logic        Reset,
    input  logic [15:0] keycode,
    input  logic        cmd_ready,
    output logic        cmd_valid,
    output logic [1:0]  cmd_dir,
    output logic [2:0]  fifo_count,
    output logic        overflow,
    output logic [8:0]  LEDG
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [7:0] DELAY_LAST  = 8'(REPEAT_DELAY - 1);
    localparam logic [7:0] PERIOD_LAST = 8'(REPEAT_PERIOD - 1);

    state_t          state;
    logic [7:0]      cnt;
    logic            prev_valid;
    dir_t            prev_dir;
    logic [3:0]      held_oh;
    key_t            key;
    logic            new_key;
    logic            push;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_cnt;

    assign key     = decode_key(keycode);
    assign new_key = key.valid && (!prev_valid || key.dir != prev_dir);
    assign pop     = cmd_valid && cmd_ready;

    always_comb begin
        push = 1'b0;
        case (state)
            IDLE:    push = key.valid;
            HOLD:    push = new_key || (key.valid && cnt == DELAY_LAST);
            REPEAT:  push = new_key || (key.valid && cnt == PERIOD_LAST);
            default: push = 1'b0;
        endcase
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state      <= IDLE;
            cnt        <= '0;
            prev_valid <= 1'b0;
            prev_dir   <= UP;
            held_oh    <= '0;
            overflow   <= 1'b0;
        end else begin
            prev_valid <= key.valid;
            prev_dir   <= key.dir;
            held_oh    <= key.valid ? (4'b0001 << key.dir) : 4'b0000;
            // Sticky: only a push that finds the FIFO full with no pop to make room is lost.
            if (push && fifo_full && !pop)
                overflow <= 1'b1;
            case (state)
                IDLE: begin
                    if (key.valid) begin
                        cnt   <= '0;
                        state <= HOLD;
                    end
                end
                HOLD, REPEAT: begin
                    if (!key.valid) begin
                        state <= IDLE;
                    end else if (new_key) begin
                        cnt   <= '0;
                        state <= HOLD;
                    end else if (state == HOLD && cnt == DELAY_LAST) begin
                        cnt   <= '0;
                        state <= REPEAT;
                    end else if (state == REPEAT && cnt == PERIOD_LAST) begin
                        cnt   <= '0;
                    end else begin
                        cnt   <= cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (2)
    ) u_fifo (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .push      (push),
        .wdata     (key.dir),
        .pop       (pop),
        .rdata     (cmd_dir),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_cnt)
    );

    assign cmd_valid  = !fifo_empty;
    assign fifo_count = 3'(fifo_cnt);
    assign LEDG       = {overflow, 4'b0000, held_oh};

endmodule

// File: tb/tb_key_cmd_gen.sv
// tb/tb_key_cmd_gen.sv - directed and randomized checks of key_cmd_gen against a frame-level model
module tb_key_cmd_gen;
    localparam int RD    = 30;
    localparam int RP    = 10;
    localparam int DEPTH = 4;

    logic        frame_clk = 1'b0;
    logic        Reset;
    logic [15:0] keycode;
    logic        cmd_ready;
    logic        cmd_valid;
    logic [1:0]  cmd_dir;
    logic [2:0]  fifo_count;
    logic        overflow;
    logic [8:0]  LEDG;

    key_cmd_gen #(
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .frame_clk  (frame_clk),
        .Reset      (Reset),
        .keycode    (keycode),
        .cmd_ready  (cmd_ready),
        .cmd_valid  (cmd_valid),
        .cmd_dir    (cmd_dir),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .LEDG       (LEDG)
    );

    always #5 frame_clk = ~frame_clk;

    int total = 0;
    int bad   = 0;
    int frame = 0;

    // Model: which direction is held and for how many frames, plus a bounded queue.
    int   held = -1;
    int   held_n = 0;
    int   q[$];
    logic m_ovf = 1'b0;

    int   valid_log[$];
    int   pop_log[$];

    function automatic int dec(input logic [15:0] k);
        case (k)
            16'h001A: return 0;
            16'h0004: return 1;
            16'h0007: return 2;
            16'h0016: return 3;
            default:  return -1;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [15:0] k, input logic r, input logic rst);
        int  d;
        bit  m_push;
        logic [8:0] exp_led;
        keycode   = k;
        cmd_ready = r;
        Reset     = rst;
        #1;
        if (!rst && cmd_valid === 1'b1 && r)
            pop_log.push_back(int'(cmd_dir));
        m_push = 0;
        d = dec(k);
        if (rst) begin
            q.delete();
            m_ovf  = 1'b0;
            held   = -1;
            held_n = 0;
        end else begin
            if (d < 0) begin
                held = -1;
            end else if (d != held) begin
                m_push = 1;
                held   = d;
                held_n = 0;
            end else begin
                held_n++;
                m_push = (held_n == RD) || (held_n > RD && (held_n - RD) % RP == 0);
            end
            if (q.size() > 0 && r)
                void'(q.pop_front());
            if (m_push) begin
                if (q.size() < DEPTH) q.push_back(d);
                else m_ovf = 1'b1;
            end
        end
        @(posedge frame_clk);
        #1;
        exp_led = {m_ovf, 4'b0000, (held >= 0) ? (4'b0001 << held) : 4'b0000};
        check("cmd_valid", 32'(cmd_valid), 32'(q.size() != 0));
        check("cmd_dir", 32'(cmd_dir), (q.size() != 0) ? 32'(q[0]) : 32'd0);
        check("fifo_count", 32'(fifo_count), 32'(q.size()));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("LEDG", 32'(LEDG), 32'(exp_led));
        if (cmd_valid === 1'b1)
            valid_log.push_back(frame);
        frame++;
    endtask

    initial begin
        int base;
        int exp_hold[4]  = '{0, 30, 40, 50};
        int exp_chg[3]   = '{0, 10, 40};
        int exp_pops[4]  = '{1, 3, 1, 3};
        logic [15:0] keys[6] = '{16'h001A, 16'h0004, 16'h0007, 16'h0016, 16'h0000, 16'h1234};

        // Reset state
        step(16'h0000, 1'b0, 1'b1);
        step(16'h0000, 1'b0, 1'b1);
        check("reset_outputs", 32'({cmd_valid, cmd_dir, fifo_count, overflow, LEDG}), 32'd0);

        // Single press
        valid_log.delete();
        step(16'h001A, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(16'h0000, 1'b1, 1'b0);
        check("single_press_valid_frames", valid_log.size(), 1);

        // Long hold: first push, then delay, then periodic repeats
        valid_log.delete();
        base = frame;
        for (int i = 0; i < 60; i++) step(16'h0007, 1'b1, 1'b0);
        check("hold_push_count", valid_log.size(), 4);
        for (int i = 0; i < 4 && i < valid_log.size(); i++)
            check("hold_push_frame", valid_log[i] - base, exp_hold[i]);
        for (int i = 0; i < 3; i++) step(16'h0000, 1'b1, 1'b0);

        // Backpressure and overflow
        for (int i = 0; i < 6; i++) step((i % 2) ? 16'h0016 : 16'h0004, 1'b0, 1'b0);
        step(16'h0000, 1'b0, 1'b0);
        check("bp_count", 32'(fifo_count), 32'd4);
        check("bp_overflow", 32'(overflow), 32'd1);
        check("bp_ledg8", 32'(LEDG[8]), 32'd1);
        pop_log.delete();
        for (int i = 0; i < 6; i++) step(16'h0000, 1'b1, 1'b0);
        check("bp_pop_count", pop_log.size(), 4);
        for (int i = 0; i < 4 && i < pop_log.size(); i++)
            check("bp_pop_dir", pop_log[i], exp_pops[i]);
        check("overflow_sticky", 32'(overflow), 32'd1);

        // Full FIFO with simultaneous push and pop
        step(16'h0000, 1'b0, 1'b1);
        step(16'h001A, 1'b0, 1'b0);
        step(16'h0004, 1'b0, 1'b0);
        step(16'h0007, 1'b0, 1'b0);
        step(16'h0016, 1'b0, 1'b0);
        step(16'h001A, 1'b1, 1'b0);
        check("full_pp_count", 32'(fifo_count), 32'd4);
        check("full_pp_overflow", 32'(overflow), 32'd0);
        for (int i = 0; i < 6; i++) step(16'h0000, 1'b1, 1'b0);

        // Key change mid-hold restarts the repeat delay
        valid_log.delete();
        base = frame;
        for (int i = 0; i < 10; i++) step(16'h001A, 1'b1, 1'b0);
        for (int i = 0; i < 35; i++) step(16'h0016, 1'b1, 1'b0);
        check("chg_push_count", valid_log.size(), 3);
        for (int i = 0; i < 3 && i < valid_log.size(); i++)
            check("chg_push_frame", valid_log[i] - base, exp_chg[i]);
        step(16'h0000, 1'b1, 1'b0);

        // Reset mid-hold with two pending commands
        step(16'h001A, 1'b0, 1'b0);
        step(16'h0004, 1'b0, 1'b0);
        step(16'h0004, 1'b0, 1'b0);
        check("pre_reset_count", 32'(fifo_count), 32'd2);
        step(16'h0004, 1'b0, 1'b1);
        check("mid_reset_outputs", 32'({cmd_valid, cmd_dir, fifo_count, overflow, LEDG}), 32'd0);
        step(16'h0004, 1'b0, 1'b0);
        check("post_reset_valid", 32'(cmd_valid), 32'd1);
        check("post_reset_dir", 32'(cmd_dir), 32'd1);

        // Randomized key bursts and ready patterns
        for (int b = 0; b < 40; b++) begin
            logic [15:0] k;
            int          dur;
            k   = keys[$urandom_range(0, 5)];
            dur = $urandom_range(1, 45);
            for (int i = 0; i < dur; i++)
                step(k, ($urandom_range(0, 3) != 0), ($urandom_range(0, 299) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
